// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - collects skewed MAC lane results, requantizes, packs and writes words to BRAM
// Optional feature macro: RESULT_WB_RELU_EN (clamp negative lanes to zero before shift/saturate)
module result_writeback #(
    parameter int ACC_W     = 16,
    parameter int N_MACS    = 4,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 0,
    parameter int MEM_DEPTH = 256,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [AW:0]               num_words,
    input  logic signed [ACC_W-1:0]   acc_in_0,
    input  logic signed [ACC_W-1:0]   acc_in_1,
    input  logic signed [ACC_W-1:0]   acc_in_2,
    input  logic signed [ACC_W-1:0]   acc_in_3,
    input  logic [N_MACS-1:0]         valid_in,
    output logic [AW-1:0]             out_bram_addr,
    output logic                      out_bram_en,
    output logic                      out_bram_we,
    output logic [N_MACS*ACC_W-1:0]   out_bram_din,
    output logic                      busy,
    output logic                      done,
    output logic                      collision
);

    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            base_q;
    logic [AW:0]              num_q;
    logic [AW:0]              word_idx_q;
    logic [N_MACS-1:0]        mask_q;
    logic signed [ACC_W-1:0]  lane_q [N_MACS];
    logic signed [ACC_W-1:0]  acc_vec [N_MACS];
    logic [N_MACS*ACC_W-1:0]  din_next;
    logic [AW-1:0]            addr_next;
    logic [AW:0]              addr_sum;
    logic                     word_complete;
    logic                     last_word;

    // Requantize one lane: optional ReLU, arithmetic shift, saturate, sign-extend.
    function automatic logic [ACC_W-1:0] process_lane(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] s;
        int                      si;
        r = v;
`ifdef RESULT_WB_RELU_EN
        if (v[ACC_W-1]) r = '0;
`endif
        s  = r >>> SHIFT;
        si = int'(s);
        if (si > SAT_MAX)      si = SAT_MAX;
        else if (si < SAT_MIN) si = SAT_MIN;
        return ACC_W'(si);
    endfunction

    assign acc_vec[0] = acc_in_0;
    assign acc_vec[1] = acc_in_1;
    assign acc_vec[2] = acc_in_2;
    assign acc_vec[3] = acc_in_3;

    assign out_bram_we = out_bram_en;

    // Word completion, merged lane packing and wrapped write address.
    always_comb begin
        word_complete = (state_q == COLLECT) && ((mask_q | valid_in) == {N_MACS{1'b1}});
        last_word     = (word_idx_q + 1'b1) == num_q;
        din_next      = '0;
        for (int i = 0; i < N_MACS; i++) begin
            din_next[i*ACC_W +: ACC_W] = process_lane(mask_q[i] ? lane_q[i] : acc_vec[i]);
        end
        // Sum fits in AW+1 bits; one conditional subtract gives the modulo for any depth.
        addr_sum = {1'b0, base_q} + {1'b0, word_idx_q[AW-1:0]};
        if (addr_sum >= (AW+1)'(MEM_DEPTH)) addr_sum = addr_sum - (AW+1)'(MEM_DEPTH);
        addr_next = addr_sum[AW-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (num_words == '0) ? FINISH : COLLECT;
            COLLECT: if (word_complete && last_word) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane capture, collision tracking, write strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q        <= '0;
            num_q         <= '0;
            word_idx_q    <= '0;
            mask_q        <= '0;
            out_bram_en   <= 1'b0;
            out_bram_addr <= '0;
            out_bram_din  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            collision     <= 1'b0;
            for (int i = 0; i < N_MACS; i++) lane_q[i] <= '0;
        end else begin
            out_bram_en <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        num_q      <= num_words;
                        word_idx_q <= '0;
                        mask_q     <= '0;
                        collision  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                COLLECT: begin
                    // A valid on an already-filled lane is dropped and flagged.
                    if ((valid_in & mask_q) != '0) collision <= 1'b1;
                    if (word_complete) begin
                        out_bram_en   <= 1'b1;
                        out_bram_addr <= addr_next;
                        out_bram_din  <= din_next;
                        mask_q        <= '0;
                        word_idx_q    <= word_idx_q + 1'b1;
                    end else begin
                        for (int i = 0; i < N_MACS; i++) begin
                            if (valid_in[i] && !mask_q[i]) begin
                                lane_q[i] <= acc_vec[i];
                                mask_q[i] <= 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - directed self-checking bench for result_writeback
module tb_result_writeback;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         base_addr;
    logic [8:0]         num_words;
    logic signed [15:0] a0, a1, a2, a3;
    logic [3:0]         valid_in;

    logic [7:0]  addr0, addr2;
    logic        en0, en2, we0, we2, busy0, busy2, done0, done2, col0, col2;
    logic [63:0] din0, din2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_writeback #(.ACC_W(16), .N_MACS(4), .OUT_W(8), .SHIFT(0), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3), .valid_in(valid_in),
        .out_bram_addr(addr0), .out_bram_en(en0), .out_bram_we(we0), .out_bram_din(din0),
        .busy(busy0), .done(done0), .collision(col0)
    );

    result_writeback #(.ACC_W(16), .N_MACS(4), .OUT_W(8), .SHIFT(2), .MEM_DEPTH(256)) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3), .valid_in(valid_in),
        .out_bram_addr(addr2), .out_bram_en(en2), .out_bram_we(we2), .out_bram_din(din2),
        .busy(busy2), .done(done2), .collision(col2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lanes(input logic signed [15:0] v0, input logic signed [15:0] v1,
                         input logic signed [15:0] v2, input logic signed [15:0] v3,
                         input logic [3:0] v);
        a0 = v0; a1 = v1; a2 = v2; a3 = v3; valid_in = v;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        lanes(0, 0, 0, 0, 4'h0);
        tick(); tick();
        check("rst_en", en0, 0);
        check("rst_we", we0, 0);
        check("rst_addr", addr0, 0);
        check("rst_din", din0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_col", col0, 0);

        // Single word, all lanes at once
        rst = 1'b0; base_addr = 8'h10; num_words = 9'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("t1_busy", busy0, 1);
        check("t1_en_early", en0, 0);
        lanes(5, 6, 7, 8, 4'hF);
        tick(); lanes(0, 0, 0, 0, 4'h0);
        check("t1_en", en0, 1);
        check("t1_we", we0, 1);
        check("t1_addr", addr0, 8'h10);
        check("t1_din", din0, 64'h0008_0007_0006_0005);
        check("t1_done_early", done0, 0);
        tick();
        check("t1_en_off", en0, 0);
        check("t1_done", done0, 1);
        check("t1_busy_off", busy0, 0);
        tick();
        check("t1_done_pulse", done0, 0);

        // Skewed arrival
        base_addr = 8'h20; num_words = 9'd1; start = 1'b1;
        tick(); start = 1'b0;
        lanes(1, 0, 0, 0, 4'h1); tick(); check("t2_en_c0", en0, 0);
        lanes(0, 2, 0, 0, 4'h2); tick(); check("t2_en_c1", en0, 0);
        lanes(0, 0, 3, 0, 4'h4); tick(); check("t2_en_c2", en0, 0);
        lanes(0, 0, 0, 4, 4'h8); tick(); lanes(0, 0, 0, 0, 4'h0);
        check("t2_en", en0, 1);
        check("t2_addr", addr0, 8'h20);
        check("t2_din", din0, 64'h0004_0003_0002_0001);
        tick();
        check("t2_done", done0, 1);
        tick();

        // Saturation
        base_addr = 8'h30; num_words = 9'd1; start = 1'b1;
        tick(); start = 1'b0;
        lanes(1000, -1000, 100, -3, 4'hF);
        tick(); lanes(0, 0, 0, 0, 4'h0);
        check("t3_en_s2", en2, 1);
`ifdef RESULT_WB_RELU_EN
        check("t3_din_s2", din2, 64'h0000_0019_0000_007F);
        check("t3_din_s0", din0, 64'h0000_0064_0000_007F);
`else
        check("t3_din_s2", din2, 64'hFFFF_0019_FF80_007F);
        check("t3_din_s0", din0, 64'hFFFD_0064_FF80_007F);
`endif
        tick(); tick();

        // Wrap, collision, back-to-back, trailing words ignored
        base_addr = 8'hFF; num_words = 9'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("t4_col_clr", col0, 0);
        lanes(11, 0, 0, 0, 4'h1); tick();
        lanes(99, 0, 0, 0, 4'h1); tick();
        check("t4_col_set", col0, 1);
        check("t4_en_dup", en0, 0);
        lanes(0, 12, 13, 14, 4'hE); tick();
        check("t4_w0_en", en0, 1);
        check("t4_w0_addr", addr0, 8'hFF);
        check("t4_w0_din", din0, 64'h000E_000D_000C_000B);
        lanes(21, 22, 23, 24, 4'hF); tick();
        check("t4_w1_en", en0, 1);
        check("t4_w1_addr", addr0, 8'h00);
        check("t4_w1_din", din0, 64'h0018_0017_0016_0015);
        lanes(31, 32, 33, 34, 4'hF); tick();
        check("t4_w2_en", en0, 0);
        check("t4_done", done0, 1);
        lanes(41, 42, 43, 44, 4'hF); tick();
        check("t4_w3_en", en0, 0);
        lanes(0, 0, 0, 0, 4'h0); tick();
        check("t4_col_held", col0, 1);

        // num_words = 0
        base_addr = 8'h40; num_words = 9'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("t5_col_clr", col0, 0);
        check("t5_en_c1", en0, 0);
        check("t5_done_c1", done0, 0);
        check("t5_busy", busy0, 1);
        tick();
        check("t5_en_c2", en0, 0);
        check("t5_done_c2", done0, 1);
        tick();
        check("t5_done_c3", done0, 0);

        // Reset mid-word, reset beats start, then normal restart
        base_addr = 8'h50; num_words = 9'd1; start = 1'b1;
        tick(); start = 1'b0;
        lanes(1, 2, 3, 0, 4'h7); tick();
        lanes(0, 0, 0, 4, 4'h8); rst = 1'b1; tick();
        lanes(0, 0, 0, 0, 4'h0);
        check("t6_en", en0, 0);
        check("t6_addr", addr0, 0);
        check("t6_din", din0, 0);
        check("t6_busy", busy0, 0);
        check("t6_done", done0, 0);
        start = 1'b1; tick();
        check("t6_rst_wins", busy0, 0);
        rst = 1'b0; base_addr = 8'h60; num_words = 9'd1;
        tick(); start = 1'b0;
        check("t6_restart_busy", busy0, 1);
        lanes(0, 0, 0, 9, 4'h8); tick();
        check("t6_no_stale", en0, 0);
        lanes(7, 7, 7, 0, 4'h7); tick(); lanes(0, 0, 0, 0, 4'h0);
        check("t6_en2", en0, 1);
        check("t6_addr2", addr0, 8'h60);
        check("t6_din2", din0, 64'h0009_0007_0007_0007);
        tick();
        check("t6_done2", done0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream consumer of the MAC-array outputs of `top_system_nn`. It collects the four per-lane accumulator results (`acc_out_0..3` / `valid_out`), which arrive skewed across cycles. Each lane is requantized (arithmetic shift plus saturation) and the four lanes are packed into one 64-bit word. The block writes a programmed number of these words to the output BRAM starting at a base address, then pulses `done`.

## Interface
- `ACC_W`, 16: accumulator/lane width; also the width of each packed lane slot.
- `N_MACS`, 4: number of lanes per output word.
- `OUT_W`, 8: signed saturation width applied to each lane.
- `SHIFT`, 0: arithmetic right shift applied before saturation (0..ACC_W-1).
- `MEM_DEPTH`, 256: output BRAM depth; AW = $clog2(MEM_DEPTH).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: 1-cycle pulse; latches `base_addr` and `num_words`; ignored while `busy`.
- `base_addr` in AW: first output word address.
- `num_words` in AW+1: number of words to write (0..MEM_DEPTH).
- `acc_in_0..acc_in_3` in ACC_W signed: lane results, connected to `acc_out_0..3`.
- `valid_in` in N_MACS: per-lane capture strobe, connected to `valid_out`.
- `out_bram_addr` out AW: write address.
- `out_bram_en` out 1: BRAM enable.
- `out_bram_we` out 1: write enable; always equal to `out_bram_en`.
- `out_bram_din` out N_MACS*ACC_W: packed word; lane i occupies bits [i*ACC_W +: ACC_W].
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: 1-cycle pulse on completion.
- `collision` out 1: sticky error flag; cleared by `rst` or by an accepted `start`.

## Operation
- FSM states: IDLE, COLLECT, FINISH.
- IDLE:
  - An accepted `start` latches the parameters, clears the capture mask, word counter and `collision`, and moves to COLLECT.
  - `valid_in` is ignored in IDLE.
- COLLECT, capture:
  - For each lane i with `valid_in[i]=1` and mask bit i clear, capture `acc_in_i` and set mask bit i.
  - If mask bit i is already set (a duplicate before the word completes), drop the new value and set `collision`.
- COLLECT, word complete: when (mask | incoming valids) == all ones at a clock edge:
  - Compute the processed word from the merged lane values and register it onto `out_bram_din`.
  - Drive `out_bram_addr` = (base_addr + word_idx) mod MEM_DEPTH.
  - Assert `en`/`we` for the next cycle.
  - Clear the mask at that same edge and increment `word_idx`.
- COLLECT, exit: the edge that completes word number `num_words` moves the FSM to FINISH.
- FINISH: lasts one cycle, in which the final write strobe is presented. `done` pulses on the following cycle, `busy` drops, and the FSM returns to IDLE.
- `num_words`=0: go directly to FINISH with no write; `done` pulses 2 cycles after `start`.
- Lane processing, in order:
  - optional ReLU (see Configuration);
  - `>>>` SHIFT;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - sign-extend back to ACC_W.

## Timing
- Reset values: `out_bram_en`=0, `out_bram_we`=0, `out_bram_addr`=0, `out_bram_din`=0, `busy`=0, `done`=0, `collision`=0; FSM in IDLE, mask and counter cleared.
- Latency: the last lane valid sampled at edge k gives `en`/`we`/`din`/`addr` high and valid during cycle k+1. The strobe is exactly one cycle wide.
- Valids arriving in cycle k+1 belong to the next word; the mask was already cleared at edge k.
- All four valids in one cycle with an empty mask complete a word immediately.
- Back-to-back words are possible at one write per cycle.
- Valids arriving after the final word is completed are ignored.
- Address wraps modulo MEM_DEPTH.
- `rst` asserted mid-operation: return to IDLE immediately. The in-flight strobe is not issued and partial lanes are discarded.
- `start` coincident with `rst`: reset wins.

## Configuration
- `RESULT_WB_RELU_EN` defined: each lane value < 0 is forced to 0 before shift and saturation.
- Not defined: signed values pass straight to shift and saturation; negative results are preserved.

## Test plan
- Reset then `start`, base=0x10, num_words=1, SHIFT=0, OUT_W=8:
  - Stimulus: lanes 0..3 = 5, 6, 7, 8, all valid in one cycle.
  - Required: one strobe the next cycle, addr=0x10, din=0x0008_0007_0006_0005; `done` pulses 2 cycles later.
- Skewed arrival:
  - Stimulus: lane0 at cycle 0, lane1 at 1, lane2 at 2, lane3 at 3, values 1..4.
  - Required: a single write in cycle 4 with din=0x0004_0003_0002_0001; no earlier strobe.
- Saturation, OUT_W=8, SHIFT=2:
  - Stimulus: lanes = 1000, -1000, 100, -3.
  - Required with RELU off: 127, -128, 25, -1, i.e. din=0xFFFF_0019_FF80_007F.
  - Required with `RESULT_WB_RELU_EN` defined: 0x0000_0019_0000_007F.
- Wrap and collision:
  - Stimulus: base=0xFF, num_words=2, four full words supplied, plus a duplicate lane0 valid mid-word-0.
  - Required: writes to 0xFF then 0x00; `collision`=1 held until the next `start`; the third and fourth words are ignored.
- `num_words`=0:
  - Required: no strobe; `done` pulses exactly 2 cycles after `start`.
- `rst` mid-word:
  - Stimulus: `rst` asserted after 3 lanes are captured.
  - Required: all outputs at reset values on the next cycle; a subsequent `start` works normally.
